// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for common-anode 7-segment digits sharing one decoder
module display_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 2,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    blank_lz_i,
    output logic [3:0]              dec_data_o,
    output logic [NUM_DIGITS-1:0]   digit_sel_o,
    output logic                    pending_o,
    output logic                    frame_done_o
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] P_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] P_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IW-1:0]    I_LAST  = IW'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      p_q, p_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         active_q, active_d;
    logic                  pending_q, pending_d;
    logic [3:0]            dec_q, dec_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  fd_q, fd_d;
    logic [3:0]            code  [NUM_DIGITS];
    logic [3:0]            shown [NUM_DIGITS];
    logic                  run_blank;
    logic                  slot_end, wrap, commit;

    // Map A-E to blank, then blank zeros that have only zeros/blanks above them (never digit 0)
    always_comb begin
        run_blank = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            code[i]   = (active_q[4*i +: 4] >= 4'hA && active_q[4*i +: 4] <= 4'hE) ? 4'hF : active_q[4*i +: 4];
            shown[i]  = (blank_lz_i && i > 0 && run_blank && code[i] == 4'h0) ? 4'hF : code[i];
            run_blank = run_blank && (code[i] == 4'h0 || code[i] == 4'hF);
        end
    end

    // Prescaler/slot stepping, double-buffer commit at frame wrap or on disable, registered outputs
    always_comb begin
        slot_end  = (p_q == P_LAST);
        wrap      = enable_i && slot_end && (idx_q == I_LAST);
        commit    = !enable_i || wrap;
        p_d       = enable_i ? (slot_end ? '0 : p_q + CNT_W'(1)) : '0;
        idx_d     = !enable_i ? '0 : (slot_end ? ((idx_q == I_LAST) ? '0 : idx_q + IW'(1)) : idx_q);
        dec_d     = (enable_i && p_q >= P_BLANK) ? shown[idx_q] : 4'hF;
        sel_d     = (enable_i && p_q >= P_BLANK) ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        shadow_d  = load_i ? digits_i : shadow_q;
        active_d  = commit ? (load_i ? digits_i : (pending_q ? shadow_q : active_q)) : active_q;
        pending_d = commit ? 1'b0 : (load_i || pending_q);
        fd_d      = wrap;
    end

    // State register with synchronous active-low reset; reset discards any pending data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q       <= '0;
            idx_q     <= '0;
            shadow_q  <= '1;
            active_q  <= '1;
            pending_q <= 1'b0;
            dec_q     <= 4'hF;
            sel_q     <= '1;
            fd_q      <= 1'b0;
        end else begin
            p_q       <= p_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            dec_q     <= dec_d;
            sel_q     <= sel_d;
            fd_q      <= fd_d;
        end
    end

    assign dec_data_o   = dec_q;
    assign digit_sel_o  = sel_q;
    assign pending_o    = pending_q;
    assign frame_done_o = fd_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed checks of scan timing, double buffering, blanking, disable and reset
module tb_display_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, enable, load, blank_lz;
    logic [15:0] digits;
    logic [3:0]  dec_data;
    logic [3:0]  digit_sel;
    logic        pending, frame_done;
    int          n_vec = 0;
    int          n_err = 0;
    int          k = 0;

    display_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .load_i(load), .digits_i(digits),
        .blank_lz_i(blank_lz), .dec_data_o(dec_data), .digit_sel_o(digit_sel),
        .pending_o(pending), .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic to_k(input int n);
        while (k < n) tick();
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s at k=%0d: observed %h expected %h", tag, k, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; blank_lz = 1'b0; digits = 16'h0000;
        tick(); tick();
        chk("rst_sel", digit_sel, 4'b1111);
        chk("rst_dec", dec_data, 4'hF);
        chk("rst_pend", 4'(pending), 4'd0);
        chk("rst_fd", 4'(frame_done), 4'd0);
        rst_n = 1'b1; enable = 1'b1; k = 0;
        to_k(1);  chk("blank0_sel", digit_sel, 4'b1111);
        to_k(2);  chk("blank1_sel", digit_sel, 4'b1111);
        to_k(3);  chk("d0_sel", digit_sel, 4'b1110);
        chk("d0_dec_F", dec_data, 4'hF);
        to_k(8);  chk("d0_last_sel", digit_sel, 4'b1110);
        to_k(9);  chk("slot1_blank", digit_sel, 4'b1111);
        to_k(11); chk("d1_sel", digit_sel, 4'b1101);
        to_k(31); chk("fd_before", 4'(frame_done), 4'd0);
        to_k(32); chk("fd_wrap1", 4'(frame_done), 4'd1);
        to_k(33); chk("fd_after", 4'(frame_done), 4'd0);
        load = 1'b1; digits = 16'h1234;
        tick(); load = 1'b0;
        chk("pend_set", 4'(pending), 4'd1);
        to_k(35); chk("no_tear_dec", dec_data, 4'hF);
        to_k(63); chk("pend_hold", 4'(pending), 4'd1);
        to_k(64); chk("pend_clr", 4'(pending), 4'd0);
        chk("fd_wrap2", 4'(frame_done), 4'd1);
        to_k(67); chk("1234_d0", dec_data, 4'h4); chk("1234_s0", digit_sel, 4'b1110);
        to_k(75); chk("1234_d1", dec_data, 4'h3); chk("1234_s1", digit_sel, 4'b1101);
        to_k(83); chk("1234_d2", dec_data, 4'h2); chk("1234_s2", digit_sel, 4'b1011);
        to_k(91); chk("1234_d3", dec_data, 4'h1); chk("1234_s3", digit_sel, 4'b0111);
        to_k(97);
        load = 1'b1; digits = 16'h0000; tick();
        digits = 16'h0056; tick(); load = 1'b0;
        chk("pend_2load", 4'(pending), 4'd1);
        to_k(128); chk("pend_clr2", 4'(pending), 4'd0);
        to_k(131); chk("56_d0", dec_data, 4'h6);
        to_k(139); chk("56_d1", dec_data, 4'h5);
        to_k(147); chk("56_d2_nolz", dec_data, 4'h0); chk("56_s2", digit_sel, 4'b1011);
        to_k(155); chk("56_d3_nolz", dec_data, 4'h0);
        to_k(160); blank_lz = 1'b1;
        to_k(163); chk("56lz_d0", dec_data, 4'h6);
        to_k(171); chk("56lz_d1", dec_data, 4'h5);
        to_k(179); chk("56lz_d2", dec_data, 4'hF); chk("56lz_s2", digit_sel, 4'b1011);
        to_k(187); chk("56lz_d3", dec_data, 4'hF); chk("56lz_s3", digit_sel, 4'b0111);
        to_k(189);
        load = 1'b1; digits = 16'h0000; tick(); load = 1'b0;
        to_k(195); chk("0lz_d0", dec_data, 4'h0); chk("0lz_s0", digit_sel, 4'b1110);
        to_k(203); chk("0lz_d1", dec_data, 4'hF);
        to_k(219); chk("0lz_d3", dec_data, 4'hF);
        to_k(223);
        load = 1'b1; digits = 16'h9ABF; tick(); load = 1'b0;
        chk("bypass_pend", 4'(pending), 4'd0);
        chk("bypass_fd", 4'(frame_done), 4'd1);
        tick(); chk("bypass_pend2", 4'(pending), 4'd0);
        to_k(227); chk("9abf_d0", dec_data, 4'hF);
        to_k(235); chk("9abf_d1", dec_data, 4'hF);
        to_k(243); chk("9abf_d2", dec_data, 4'hF);
        to_k(251); chk("9abf_d3", dec_data, 4'h9); chk("9abf_s3", digit_sel, 4'b0111);
        to_k(253);
        load = 1'b1; digits = 16'h0007; tick(); load = 1'b0;
        chk("dis_pend_set", 4'(pending), 4'd1);
        enable = 1'b0; tick();
        chk("dis_sel", digit_sel, 4'b1111);
        chk("dis_dec", dec_data, 4'hF);
        chk("dis_pend", 4'(pending), 4'd0);
        chk("dis_fd", 4'(frame_done), 4'd0);
        tick(); chk("dis_sel2", digit_sel, 4'b1111);
        enable = 1'b1; k = 0;
        to_k(2); chk("re_blank", digit_sel, 4'b1111);
        to_k(3); chk("re_sel", digit_sel, 4'b1110); chk("re_dec", dec_data, 4'h7);
        load = 1'b1; digits = 16'h1234; tick(); load = 1'b0;
        chk("rst_pend_pre", 4'(pending), 4'd1);
        rst_n = 1'b0; tick();
        chk("mrst_sel", digit_sel, 4'b1111);
        chk("mrst_dec", dec_data, 4'hF);
        chk("mrst_pend", 4'(pending), 4'd0);
        chk("mrst_fd", 4'(frame_done), 4'd0);
        rst_n = 1'b1; k = 0;
        to_k(3);  chk("post_d0", dec_data, 4'hF); chk("post_s0", digit_sel, 4'b1110);
        to_k(32); chk("post_fd", 4'(frame_done), 4'd1);
        to_k(35); chk("post_f_d0", dec_data, 4'hF);
        to_k(43); chk("post_f_d1", dec_data, 4'hF); chk("post_f_s1", digit_sel, 4'b1101);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
